// File: rtl/inst_fetch_unit.sv
// Instruction fetch requester: drives the memory word address, queues returned
// words with their pc for decode, and handles redirects and halt-on-self-jump.
module inst_fetch_unit #(
   parameter int          AW        = 8,
   parameter int          DW        = 32,
   parameter int          QDEPTH    = 2,
   parameter logic [DW-1:0] HALT_WORD = 32'hFFFF_F06F
) (
   input  logic          clk,
   input  logic          rst_n,
   output logic [AW-1:0] mem_address,
   input  logic [DW-1:0] mem_data,
   output logic          if_valid,
   input  logic          if_ready,
   output logic [DW-1:0] if_instr,
   output logic [AW-1:0] if_pc,
   input  logic          redirect_valid,
   input  logic [AW-1:0] redirect_pc,
   output logic          halted
);

   localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
   localparam int CW = $clog2(QDEPTH + 1);

   typedef enum logic {FETCH, HALT} state_t;

   state_t          state_q, state_d;
   logic [AW-1:0]   pc_q;
   logic [AW-1:0]   fl_pc_q;
   logic            inflight_q;
   logic [CW-1:0]   count_q;
   logic [PW-1:0]   rd_q, wr_q;
   logic [DW-1:0]   instr_q [QDEPTH];
   logic [AW-1:0]   pcs_q   [QDEPTH];

   logic            pop;
   logic            wr_en;
   logic            halt_hit;
   logic            issue_ok;
   logic [CW:0]     occ;

   function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
      return (p == PW'(QDEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // Credit check counts the word in flight so the queue can never overflow.
   always_comb begin
      pop      = (count_q != '0) && if_ready;
      wr_en    = inflight_q && (state_q == FETCH);
      halt_hit = wr_en && (mem_data == HALT_WORD);
      occ      = (CW+1)'(count_q) + (CW+1)'(inflight_q) - (CW+1)'(pop);
      issue_ok = (state_q == FETCH) && !redirect_valid
                 && (occ < (CW+1)'(QDEPTH));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= FETCH;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      priority case (1'b1)
         redirect_valid: state_d = FETCH;
         halt_hit:       state_d = HALT;
         default:        state_d = state_q;
      endcase
   end

   always_comb begin
      halted = (state_q == HALT);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q       <= '0;
         fl_pc_q    <= '0;
         inflight_q <= 1'b0;
         count_q    <= '0;
         rd_q       <= '0;
         wr_q       <= '0;
         for (int i = 0; i < QDEPTH; i++) begin
            instr_q[i] <= '0;
            pcs_q[i]   <= '0;
         end
      end else if (redirect_valid) begin
         pc_q       <= redirect_pc;
         inflight_q <= 1'b0;
         count_q    <= '0;
         rd_q       <= '0;
         wr_q       <= '0;
      end else begin
         inflight_q <= issue_ok;
         if (issue_ok) begin
            pc_q    <= pc_q + AW'(1);
            fl_pc_q <= pc_q;
         end
         if (wr_en) begin
            instr_q[wr_q] <= mem_data;
            pcs_q[wr_q]   <= fl_pc_q;
            wr_q          <= nxt(wr_q);
         end
         if (pop) rd_q <= nxt(rd_q);
         count_q <= count_q + CW'(wr_en) - CW'(pop);
      end
   end

   assign mem_address = pc_q;
   assign if_valid    = (count_q != '0);
   assign if_instr    = instr_q[rd_q];
   assign if_pc       = pcs_q[rd_q];

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit: per-cycle vector table plus
// hand-written stall/reset sequences against a 1-cycle-latency ROM.
module tb_inst_fetch_unit;

   localparam logic [31:0] HW = 32'hFFFF_F06F;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  mem_address;
   logic [31:0] mem_data;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_instr;
   logic [7:0]  if_pc;
   logic        redirect_valid;
   logic [7:0]  redirect_pc;
   logic        halted;

   logic [31:0] rom [256];

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic        rdy;
      logic        rv;
      logic [7:0]  rpc;
      logic [7:0]  addr;
      logic        valid;
      logic [7:0]  pc;
      logic [31:0] instr;
      logic        halt;
   } vec_t;

   vec_t vec[$];

   inst_fetch_unit dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .mem_address    (mem_address),
      .mem_data       (mem_data),
      .if_valid       (if_valid),
      .if_ready       (if_ready),
      .if_instr       (if_instr),
      .if_pc          (if_pc),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .halted         (halted)
   );

   always #5 clk = ~clk;

   always_ff @(posedge clk) mem_data <= rom[mem_address];

   task automatic add(input logic rdy, input logic rv, input int rpc,
                      input int addr, input logic valid, input int pc,
                      input logic halt);
      vec_t v;
      v.rdy   = rdy;
      v.rv    = rv;
      v.rpc   = 8'(rpc);
      v.addr  = 8'(addr);
      v.valid = valid;
      v.pc    = 8'(pc);
      v.instr = (pc == 10) ? HW : 32'(pc + 100);
      v.halt  = halt;
      vec.push_back(v);
   endtask

   task automatic chk(input string nm, input int id, input vec_t v);
      logic ok;
      ok = (mem_address == v.addr) && (if_valid == v.valid)
           && (halted == v.halt);
      if (v.valid) ok = ok && (if_pc == v.pc) && (if_instr == v.instr);
      n_cmp++;
      if (!ok) begin
         n_bad++;
         $display("FAIL %s[%0d]: got addr=%0d v=%0b pc=%0d instr=%h h=%0b, want addr=%0d v=%0b pc=%0d instr=%h h=%0b",
                  nm, id, mem_address, if_valid, if_pc, if_instr, halted,
                  v.addr, v.valid, v.pc, v.instr, v.halt);
      end
   endtask

   task automatic chk_reset(input string nm);
      n_cmp++;
      if (if_valid !== 1'b0 || halted !== 1'b0 || mem_address !== 8'd0
          || if_pc !== 8'd0 || if_instr !== 32'd0) begin
         n_bad++;
         $display("FAIL %s: got v=%0b h=%0b addr=%0d pc=%0d instr=%h, want all zero",
                  nm, if_valid, halted, mem_address, if_pc, if_instr);
      end
   endtask

   task automatic run_rows(input string nm, input int lo, input int hi);
      for (int i = lo; i <= hi; i++) begin
         if_ready       = vec[i].rdy;
         redirect_valid = vec[i].rv;
         redirect_pc    = vec[i].rpc;
         #1 chk(nm, i, vec[i]);
         @(negedge clk);
      end
   endtask

   vec_t hv;

   initial begin
      for (int k = 0; k < 256; k++) rom[k] = 32'(k + 100);
      rom[10] = HW;
      rst_n = 1'b0;
      if_ready = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc = 8'd0;

      //  rdy rv rpc  addr v pc  halt
      add(1, 0, 0,    0,  0, 0,   0);
      add(1, 0, 0,    1,  0, 0,   0);
      add(1, 0, 0,    2,  1, 0,   0);
      add(1, 0, 0,    3,  1, 1,   0);
      add(1, 0, 0,    4,  1, 2,   0);
      add(0, 0, 0,    5,  1, 3,   0);
      add(0, 0, 0,    5,  1, 3,   0);
      add(0, 0, 0,    5,  1, 3,   0);
      add(0, 0, 0,    5,  1, 3,   0);
      add(0, 0, 0,    5,  1, 3,   0);
      add(1, 0, 0,    5,  1, 3,   0);
      add(1, 0, 0,    6,  1, 4,   0);
      add(1, 0, 0,    7,  1, 5,   0);
      add(1, 0, 0,    8,  1, 6,   0);
      add(0, 0, 0,    9,  1, 7,   0);
      add(1, 1, 40,   9,  1, 7,   0);
      add(1, 0, 0,    40, 0, 0,   0);
      add(1, 0, 0,    41, 0, 0,   0);
      add(1, 0, 0,    42, 1, 40,  0);
      add(1, 1, 254,  43, 1, 41,  0);
      add(1, 0, 0,    254,0, 0,   0);
      add(1, 0, 0,    255,0, 0,   0);
      add(1, 0, 0,    0,  1, 254, 0);
      add(1, 0, 0,    1,  1, 255, 0);
      add(1, 0, 0,    2,  1, 0,   0);
      add(1, 1, 200,  3,  1, 1,   0);
      add(1, 1, 7,    200,0, 0,   0);
      add(1, 0, 0,    7,  0, 0,   0);
      add(1, 0, 0,    8,  0, 0,   0);
      add(1, 0, 0,    9,  1, 7,   0);
      add(1, 0, 0,    10, 1, 8,   0);
      add(1, 0, 0,    11, 1, 9,   0);
      add(1, 0, 0,    12, 1, 10,  1);
      add(1, 0, 0,    12, 0, 0,   1);
      add(1, 1, 0,    12, 0, 0,   1);
      add(1, 0, 0,    0,  0, 0,   0);
      add(1, 0, 0,    1,  0, 0,   0);
      add(1, 0, 0,    2,  1, 0,   0);
      add(1, 0, 0,    3,  1, 1,   0);

      repeat (3) @(negedge clk);
      #1 chk_reset("reset");
      @(negedge clk);
      rst_n = 1'b1;
      run_rows("table", 0, vec.size() - 1);

      // Fill the queue with decode stalled, then reset asynchronously.
      if_ready = 1'b0;
      hv = '{rdy:0, rv:0, rpc:0, addr:4, valid:1, pc:2, instr:102, halt:0};
      #1 chk("stall", 0, hv);
      @(negedge clk);
      #1 chk("stall", 1, hv);
      @(negedge clk);
      #1 chk("stall", 2, hv);
      #2 rst_n = 1'b0;
      #1 chk_reset("async_reset");
      @(posedge clk);
      @(negedge clk);
      #1 chk_reset("held_reset");
      @(negedge clk);
      rst_n = 1'b1;
      run_rows("restart", 0, 4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
